// File: rtl/watch_set_cu_if.sv
// rtl/watch_set_cu_if.sv - button inputs and control outputs of the watch set control unit
interface watch_set_cu_if;
    logic       i_tick;
    logic       i_mode;
    logic       i_up;
    logic       i_down;
    logic       o_set_active;
    logic [1:0] o_field_sel;
    logic       o_inc;
    logic       o_dec;
    logic       o_hold;
    logic       o_blink;

    modport master (
        output i_tick, i_mode, i_up, i_down,
        input  o_set_active, o_field_sel, o_inc, o_dec, o_hold, o_blink
    );

    modport slave (
        input  i_tick, i_mode, i_up, i_down,
        output o_set_active, o_field_sel, o_inc, o_dec, o_hold, o_blink
    );
endinterface

// File: rtl/watch_set_cu.sv
// rtl/watch_set_cu.sv - watch time-setting control unit; AUTO_REPEAT_EN enables held-button auto-repeat
module watch_set_cu #(
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
`endif
    parameter int BLINK_HALF    = 25,
    parameter int TIMEOUT       = 1000
) (
    input  logic          clk,
    input  logic          reset_n,
    watch_set_cu_if.slave bus
);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Encoding doubles as the field select code.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic          up_d, down_d;
    logic          armed, armed_nxt;
    logic          inc_q, dec_q, set_q, blink_q;
    logic          inc_nxt, dec_nxt, blink_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic          in_set, held, press_up, press_dn, timed_out;
`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
`endif

    always_comb begin
        in_set    = (state != IDLE);
        held      = bus.i_up | bus.i_down;
        press_up  = bus.i_up & ~up_d & ~bus.i_down;
        press_dn  = bus.i_down & ~down_d & ~bus.i_up;
        timed_out = in_set && (to_cnt == TW'(TIMEOUT));

        state_nxt = state;
        armed_nxt = armed;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_nxt = '0;
`endif
        // armed means the single held button earned its strobe in the current field
        if (timed_out) begin
            state_nxt = IDLE;
            armed_nxt = 1'b0;
        end else if (bus.i_mode) begin
            state_nxt = state_t'(state + 2'd1);
            armed_nxt = 1'b0;
        end else if (!in_set || !held || (bus.i_up && bus.i_down)) begin
            armed_nxt = 1'b0;
        end else if (press_up || press_dn) begin
            armed_nxt = 1'b1;
            inc_nxt   = press_up;
            dec_nxt   = press_dn;
        end
`ifdef AUTO_REPEAT_EN
        else if (armed) begin
            rep_cnt_nxt = rep_cnt;
            if (bus.i_tick) begin
                if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
                    inc_nxt     = bus.i_up;
                    dec_nxt     = bus.i_down;
                    rep_cnt_nxt = RW'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    rep_cnt_nxt = rep_cnt + RW'(1);
                end
            end
        end
`endif

        blink_nxt     = blink_q;
        blink_cnt_nxt = blink_cnt;
        if (state_nxt == IDLE || inc_nxt || dec_nxt || state_nxt != state) begin
            blink_nxt     = 1'b1;
            blink_cnt_nxt = '0;
        end else if (bus.i_tick) begin
            if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                blink_nxt     = ~blink_q;
                blink_cnt_nxt = '0;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end

        to_cnt_nxt = to_cnt;
        if (state_nxt == IDLE || bus.i_mode || held) begin
            to_cnt_nxt = '0;
        end else if (bus.i_tick && to_cnt != TW'(TIMEOUT)) begin
            to_cnt_nxt = to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            up_d      <= 1'b0;
            down_d    <= 1'b0;
            armed     <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            set_q     <= 1'b0;
            blink_q   <= 1'b1;
            blink_cnt <= '0;
            to_cnt    <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_nxt;
            up_d      <= bus.i_up;
            down_d    <= bus.i_down;
            armed     <= armed_nxt;
            inc_q     <= inc_nxt;
            dec_q     <= dec_nxt;
            set_q     <= (state_nxt != IDLE);
            blink_q   <= blink_nxt;
            blink_cnt <= blink_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
`ifdef AUTO_REPEAT_EN
            rep_cnt   <= rep_cnt_nxt;
`endif
        end
    end

    assign bus.o_set_active = set_q;
    assign bus.o_hold       = set_q;
    assign bus.o_field_sel  = state;
    assign bus.o_inc        = inc_q;
    assign bus.o_dec        = dec_q;
    assign bus.o_blink      = blink_q;
endmodule
